// File: rtl/apb_multi_slave_mem_if.sv
// APB4 bus bundle shared by the requester and the multi-slave register-file completer.
// Handshake: a transfer completes on the rising edge where psel, penable and pready are all 1.
interface apb_multi_slave_mem_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_SLAVES-1:0]   psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_multi_slave_mem.sv
// APB4 completer array: NUM_SLAVES register files behind one-hot psel, with
// programmable wait states, byte-lane writes and a saturating error counter.
module apb_multi_slave_mem #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int MAX_WAIT   = 15
) (
    input  logic                            pclk,
    input  logic                            presetn,
    apb_multi_slave_mem_if.slave            bus,
    input  logic [$clog2(MAX_WAIT+1)-1:0]   wait_cfg,
    output logic [7:0]                      err_count,
    output logic                            dbg_access
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int B  = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [NUM_SLAVES][DEPTH];
    logic [SW-1:0]         lat_slv;
    logic [IW-1:0]         lat_idx;
    logic                  lat_write;
    logic                  lat_err;
    logic [WW-1:0]         wcnt;

    logic                  sel_onehot;
    logic                  setup_err;
    logic [SW-1:0]         sidx;
    logic [IW-1:0]         widx;
    logic [WW-1:0]         wload;

    // Setup-phase decode: everything latched at the IDLE->ACCESS edge comes from here.
    always_comb begin
        sel_onehot = (bus.psel != '0) &&
                     ((bus.psel & (bus.psel - NUM_SLAVES'(1))) == '0);
        setup_err  = !sel_onehot || (|bus.paddr[B-1:0]) ||
                     (|bus.paddr[ADDR_WIDTH-1:IW+B]);
        widx       = bus.paddr[IW+B-1:B];
        wload      = (wait_cfg > WW'(MAX_WAIT)) ? WW'(MAX_WAIT) : wait_cfg;
        sidx       = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (bus.psel[i]) sidx = SW'(i);
        end
    end

    assign dbg_access = (state == ACCESS);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            bus.prdata  <= '0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            err_count   <= '0;
            lat_slv     <= '0;
            lat_idx     <= '0;
            lat_write   <= 1'b0;
            lat_err     <= 1'b0;
            wcnt        <= '0;
            for (int s = 0; s < NUM_SLAVES; s++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem[s][w] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    bus.pready  <= 1'b0;
                    bus.pslverr <= 1'b0;
                    bus.prdata  <= '0;
                    // penable without a preceding setup cycle is not a setup and is ignored.
                    if ((|bus.psel) && !bus.penable) begin
                        state     <= ACCESS;
                        lat_slv   <= sidx;
                        lat_idx   <= widx;
                        lat_write <= bus.pwrite;
                        lat_err   <= setup_err;
                        wcnt      <= wload;
                        if (wload == '0) begin
                            bus.pready  <= 1'b1;
                            bus.pslverr <= setup_err;
                            bus.prdata  <= (!bus.pwrite && !setup_err) ? mem[sidx][widx] : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.psel == '0) begin
                        state       <= IDLE;
                        bus.pready  <= 1'b0;
                        bus.pslverr <= 1'b0;
                        bus.prdata  <= '0;
                    end else if (bus.pready) begin
                        if (bus.penable) begin
                            // Write data and strobes are taken live at the completion edge.
                            if (lat_write && !lat_err) begin
                                for (int i = 0; i < NB; i++) begin
                                    if (bus.pstrb[i]) mem[lat_slv][lat_idx][8*i +: 8] <= bus.pwdata[8*i +: 8];
                                end
                            end
                            if (lat_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
                            state       <= IDLE;
                            bus.pready  <= 1'b0;
                            bus.pslverr <= 1'b0;
                            bus.prdata  <= '0;
                        end
                    end else if (bus.penable) begin
                        wcnt <= wcnt - WW'(1);
                        if (wcnt == WW'(1)) begin
                            bus.pready  <= 1'b1;
                            bus.pslverr <= lat_err;
                            bus.prdata  <= (!lat_write && !lat_err) ? mem[lat_slv][lat_idx] : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
